ijtag_scan_master: RTL and testbench

On-chip IJTAG initiator that drives the client-side scan port (`ijtag_tck`, `ijtag_reset`, `ijtag_sel`, `ijtag_ce`, `ijtag_se`, `ijtag_ue`, `ijtag_si`, `ijtag_so`) of the counter's test data register.

- Lets a local controller (BIST sequencer or debug bridge) load `mux_sel`, `fi_en`, `nRst`, `backward` and `cnt` overrides without an external TAP.
- Reads the captured `led` state back through the same scan.
- Each request runs one capture-shift-update pass and returns the shifted-out bits.

---
 rtl/ijtag_scan_master_pkg.sv | 12 +
 rtl/ijtag_scan_master_tck_phase.sv | 16 +
 rtl/ijtag_scan_master.sv | 127 ++++++++++++
 tb/tb_ijtag_scan_master.sv | 124 ++++++++++++
 4 files changed

// File: rtl/ijtag_scan_master_pkg.sv
// ijtag_scan_master_pkg: state encodings, reset length and tck phase constants
package ijtag_scan_master_pkg;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RST     = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_SHIFT   = 3'd3;
  localparam logic [2:0] S_UPDATE  = 3'd4;
  localparam logic [2:0] S_FIN     = 3'd5;
  localparam int RST_TCKS = 2;
  localparam logic PH0 = 1'b0;
  localparam logic PH1 = 1'b1;
endpackage

// File: rtl/ijtag_scan_master_tck_phase.sv
// ijtag_tck_phase: clk/2 scan clock with strobes for the edge that ends each phase
module ijtag_tck_phase
  import ijtag_scan_master_pkg::*;
(
  input  logic clk,
  input  logic nRst,
  output logic tck,
  output logic phase_fall,
  output logic phase_rise
);
  always_ff @(posedge clk)
    if (!nRst) tck <= PH0;
    else tck <= ~tck;
  assign phase_fall = tck == PH1;
  assign phase_rise = tck == PH0;
endmodule

// File: rtl/ijtag_scan_master.sv
// ijtag_scan_master: capture-shift-update initiator for a client IJTAG scan port
module ijtag_scan_master
  import ijtag_scan_master_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               start,
  input  logic               rst_req,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] wr_data,
  output logic               busy,
  output logic               done,
  output logic [MAX_LEN-1:0] rd_data,
  output logic               ijtag_tck,
  output logic               ijtag_reset,
  output logic               ijtag_sel,
  output logic               ijtag_ce,
  output logic               ijtag_se,
  output logic               ijtag_ue,
  output logic               ijtag_si,
  input  logic               ijtag_so
);
  logic [2:0] state;
  logic [LEN_W-1:0] len_q, cnt;
  logic [MAX_LEN-1:0] wr_q, ptr;
  logic pend, pend_rst, phase_fall, phase_rise, acc, acc_rst, launch;
  ijtag_tck_phase u_phase (
    .clk(clk), .nRst(nRst), .tck(ijtag_tck), .phase_fall(phase_fall), .phase_rise(phase_rise)
  );
  always_comb begin
    acc     = state == S_IDLE && !pend && (start || rst_req);
    acc_rst = pend ? pend_rst : rst_req;
    launch  = state == S_IDLE && phase_fall && (pend || acc);
  end
  // ptr is a one-hot shift pointer so rd_data/wr_q need no variable-width indexing
  always_ff @(posedge clk)
    if (!nRst) begin
      state <= S_IDLE;
      pend <= 1'b0;
      pend_rst <= 1'b0;
      len_q <= '0;
      wr_q <= '0;
      cnt <= '0;
      ptr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      rd_data <= '0;
      ijtag_reset <= 1'b0;
      ijtag_sel <= 1'b0;
      ijtag_ce <= 1'b0;
      ijtag_se <= 1'b0;
      ijtag_ue <= 1'b0;
      ijtag_si <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != S_RST) ijtag_reset <= 1'b1;
      if (acc) begin
        busy <= 1'b1;
        pend_rst <= rst_req;
        if (!rst_req) begin
          len_q <= len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : len;
          wr_q <= wr_data;
          rd_data <= '0;
        end
      end
      pend <= launch ? 1'b0 : (acc && phase_rise) ? 1'b1 : pend;
      if (state == S_FIN) state <= S_IDLE;
      if (launch) begin
        if (acc_rst) begin
          state <= S_RST;
          ijtag_reset <= 1'b0;
          cnt <= LEN_W'(RST_TCKS - 1);
        end else begin
          state <= S_CAPTURE;
          ijtag_sel <= 1'b1;
          ijtag_ce <= 1'b1;
        end
      end else if (phase_fall) begin
        case (state)
          S_RST:
            if (cnt == '0) begin
              state <= S_FIN;
              ijtag_reset <= 1'b1;
              busy <= 1'b0;
              done <= 1'b1;
            end else cnt <= cnt - 1'b1;
          S_CAPTURE: begin
            ijtag_ce <= 1'b0;
            if (len_q == '0) begin
              state <= S_UPDATE;
              ijtag_ue <= 1'b1;
            end else begin
              state <= S_SHIFT;
              ijtag_se <= 1'b1;
              ijtag_si <= wr_q[0];
              ptr <= MAX_LEN'(1);
              cnt <= len_q - 1'b1;
            end
          end
          S_SHIFT: begin
            rd_data <= rd_data | (ijtag_so ? ptr : '0);
            ptr <= ptr << 1;
            if (cnt == '0) begin
              state <= S_UPDATE;
              ijtag_se <= 1'b0;
              ijtag_si <= 1'b0;
              ijtag_ue <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
              ijtag_si <= |(wr_q & (ptr << 1));
            end
          end
          S_UPDATE: begin
            state <= S_FIN;
            ijtag_sel <= 1'b0;
            ijtag_ue <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_ijtag_scan_master.sv
// tb_ijtag_scan_master: directed bench with a 9-bit client TDR model ({data[4:0], led=4'hA})
module tb_ijtag_scan_master;
  logic clk = 1'b0, nRst = 1'b0, start = 1'b0, rst_req = 1'b0;
  logic [4:0] len = '0;
  logic [15:0] wr_data = '0;
  logic busy, done, ijtag_tck, ijtag_reset, ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si;
  logic [15:0] rd_data;
  logic ijtag_so = 1'b0;
  logic [8:0] sr = '0;
  logic [4:0] data_reg = '0;
  int tests = 0, fails = 0;
  int se_cnt = 0, ue_cnt = 0, ce_cnt = 0, done_cnt = 0, rlow_cnt = 0;
  always #5 clk = ~clk;
  ijtag_scan_master dut (
    .clk(clk), .nRst(nRst), .start(start), .rst_req(rst_req), .len(len), .wr_data(wr_data),
    .busy(busy), .done(done), .rd_data(rd_data), .ijtag_tck(ijtag_tck), .ijtag_reset(ijtag_reset),
    .ijtag_sel(ijtag_sel), .ijtag_ce(ijtag_ce), .ijtag_se(ijtag_se), .ijtag_ue(ijtag_ue),
    .ijtag_si(ijtag_si), .ijtag_so(ijtag_so)
  );
  always @(posedge ijtag_tck or negedge ijtag_reset)
    if (!ijtag_reset) begin
      sr <= '0;
      data_reg <= '0;
    end else if (ijtag_sel) begin
      if (ijtag_ce) sr <= {data_reg, 4'hA};
      else if (ijtag_se) sr <= {ijtag_si, sr[8:1]};
      else if (ijtag_ue) data_reg <= sr[8:4];
    end
  always @(negedge ijtag_tck or negedge ijtag_reset)
    if (!ijtag_reset) ijtag_so <= 1'b0;
    else ijtag_so <= sr[0];
  always @(posedge ijtag_tck) begin
    if (ijtag_sel && ijtag_se) se_cnt++;
    if (ijtag_sel && ijtag_ue) ue_cnt++;
    if (ijtag_sel && ijtag_ce) ce_cnt++;
  end
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!ijtag_reset) rlow_cnt++;
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic check_rng(input string nm, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask
  task automatic run_vec(input string nm, input logic [4:0] l, input logic [15:0] w,
                         input logic [15:0] erd, input int ese, input logic [4:0] edata, input bit poke);
    int se0, ue0, ce0, d0, n, le;
    se0 = se_cnt; ue0 = ue_cnt; ce0 = ce_cnt; d0 = done_cnt;
    le = l > 16 ? 16 : int'(l);
    start = 1'b1; len = l; wr_data = w;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (poke) start = (n == 8);
    end while (!done && n < 200);
    start = 1'b0;
    check_rng({nm, " latency"}, n, 2 * le + 5, 2 * le + 6);
    check({nm, " rd_data"}, 32'(rd_data), 32'(erd));
    @(negedge clk);
    check({nm, " se periods"}, se_cnt - se0, ese);
    check({nm, " ce/ue/done"}, {ce_cnt - ce0, ue_cnt - ue0, done_cnt - d0}, {32'd1, 32'd1, 32'd1});
    check({nm, " client data"}, 32'(data_reg), 32'(edata));
  endtask
  typedef struct {string nm; logic [4:0] l; logic [15:0] w; logic [15:0] rd; int se; logic [4:0] data;} vec_t;
  vec_t v[5];
  initial begin
    int se0, ue0, ce0, d0, r0, n;
    v[0] = '{"len9_1f3", 5'd9, 16'h01F3, 16'h000A, 9, 5'h1F};
    v[1] = '{"len9_0a5", 5'd9, 16'h00A5, 16'h01FA, 9, 5'h0A};
    v[2] = '{"len0", 5'd0, 16'hFFFF, 16'h0000, 0, 5'h0A};
    v[3] = '{"len4", 5'd4, 16'h000C, 16'h000A, 4, 5'h18};
    v[4] = '{"len20_clamp", 5'd20, 16'hFFFF, 16'hFF8A, 16, 5'h1F};
    repeat (3) @(negedge clk);
    check("reset outputs", {ijtag_tck, ijtag_reset, ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, busy, done, rd_data},
          '0);
    nRst = 1'b1;
    @(posedge clk); #1;
    check("reset release", 32'(ijtag_reset), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) run_vec(v[i].nm, v[i].l, v[i].w, v[i].rd, v[i].se, v[i].data, 1'b0);
    d0 = done_cnt; ce0 = ce_cnt; r0 = rlow_cnt;
    start = 1'b1; rst_req = 1'b1; len = 5'd9;
    @(posedge clk); #1 start = 1'b0; rst_req = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_req low cycles", rlow_cnt - r0, 4);
    check("rst_req done/ce", {done_cnt - d0, ce_cnt - ce0}, {32'd1, 32'd0});
    check("rst_req client data", 32'(data_reg), 32'd0);
    run_vec("start_in_shift", 5'd9, 16'h0155, 16'h000A, 9, 5'h15, 1'b1);
    run_vec("back_to_back", 5'd9, 16'h0000, 16'h015A, 9, 5'h00, 1'b0);
    se0 = se_cnt; ue0 = ue_cnt; d0 = done_cnt;
    start = 1'b1; len = 5'd9; wr_data = 16'h01F3;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (se_cnt - se0 < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort reached shift", 32'(n < 100), 32'd1);
    @(negedge clk) nRst = 1'b0;
    @(posedge clk); #1;
    check("abort outputs", {ijtag_tck, ijtag_reset, ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, busy, done, rd_data},
          '0);
    repeat (4) @(negedge clk);
    nRst = 1'b1;
    repeat (4) @(negedge clk);
    check("abort no ue/done", {ue_cnt - ue0, done_cnt - d0}, '0);
    check("abort client reset", 32'(data_reg), 32'd0);
    run_vec("after_abort", 5'd9, 16'h01F3, 16'h000A, 9, 5'h1F, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
